// File: rtl/rv32_multicycle_sequencer_pkg.sv
// rv32_multicycle_sequencer_pkg: shared types and constants for the multi-cycle sequencer.
//   state_e       FSM state encoding, also exported on state_o for debug
//   trap_cause_e  code reported on trap_cause_o
//   NOP_INSTR     instruction register reset value (addi x0, x0, 0)
//   LSU_*         decoder load/store opcode width and the codes the sequencer cares about
package rv32_multicycle_sequencer_pkg;

    localparam int LSU_OPCODE_WIDTH = 4;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_NONE    = 4'd0;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_LOAD_W  = 4'd1;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_STORE_W = 4'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_MISALIGNED = 2'd0,
        CAUSE_IMEM_TO    = 2'd1,
        CAUSE_DMEM_TO    = 2'd2
    } trap_cause_e;

endpackage

// File: rtl/rv32_multicycle_sequencer_bus_timeout.sv
// rv32_bus_timeout: counts consecutive bus wait cycles and flags the LIMIT-th one.
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        a request is outstanding and not acknowledged this cycle
//   expired_o   this is the LIMIT-th consecutive waiting cycle
module rv32_bus_timeout #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    // Any cycle without a pending wait clears the count, so every FETCH/MEM entry starts at zero.
    always_comb count_d = en_i ? count_q + CW'(1) : '0;

    assign expired_o = en_i && (count_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/rv32_multicycle_sequencer.sv
// rv32_multicycle_sequencer: one-instruction-in-flight control FSM (fetch/decode/execute/mem/writeback/trap).
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_o/addr_o/ack_i/rdata_i  instruction fetch handshake, address = pc_o
//   instr_o                          latched instruction for the decoder
//   reg_w_i, mem_w_i, lsu_opcode_i   decoder controls
//   is_branch_i, branch_taken_i,
//   branch_target_i                  branch unit result (taken also asserted for unconditional jumps)
//   dmem_req_o/we_o/ack_i            data access handshake
//   rf_we_o                          register-file write strobe
//   pc_o, state_o                    current PC and FSM state
//   trap_o, trap_cause_o             trap pulse and latched cause
module rv32_multicycle_sequencer
    import rv32_multicycle_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int          BUS_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req_o,
    output logic [31:0]                 imem_addr_o,
    input  logic                        imem_ack_i,
    input  logic [31:0]                 imem_rdata_i,
    output logic [31:0]                 instr_o,
    input  logic                        reg_w_i,
    input  logic                        mem_w_i,
    input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
    input  logic                        is_branch_i,
    input  logic                        branch_taken_i,
    input  logic [31:0]                 branch_target_i,
    output logic                        dmem_req_o,
    output logic                        dmem_we_o,
    input  logic                        dmem_ack_i,
    output logic                        rf_we_o,
    output logic [31:0]                 pc_o,
    output logic [2:0]                  state_o,
    output logic                        trap_o,
    output logic [1:0]                  trap_cause_o
);

    state_e      state_q, state_d;
    trap_cause_e cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        in_fetch, in_mem, wait_en, expired, take;

    assign in_fetch = state_q == ST_FETCH;
    assign in_mem   = state_q == ST_MEM;
    assign wait_en  = (in_fetch && !imem_ack_i) || (in_mem && !dmem_ack_i);
    assign take     = is_branch_i && branch_taken_i;

    rv32_bus_timeout #(
        .LIMIT     (BUS_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (wait_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_FETCH: begin
                // Ack is checked first so an ack on the expiry cycle still completes the fetch.
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    state_d = ST_DECODE;
                end else if (expired) begin
                    cause_d = CAUSE_IMEM_TO;
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (take && branch_target_i[1:0] != 2'b00) begin
                    cause_d = CAUSE_MISALIGNED;
                    state_d = ST_TRAP;
                end else begin
                    state_d = lsu_opcode_i != LSU_NONE ? ST_MEM : ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                if (dmem_ack_i) begin
                    state_d = ST_WRITEBACK;
                end else if (expired) begin
                    cause_d = CAUSE_DMEM_TO;
                    state_d = ST_TRAP;
                end
            end
            ST_WRITEBACK: begin
                pc_d    = take ? branch_target_i : pc_q + 32'd4;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                pc_d    = TRAP_VECTOR;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_MISALIGNED;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Strobes are pure decodes of the state register; the decoder inputs they qualify are held
    // stable for the whole instruction because they derive from the latched instr_o.
    assign imem_req_o   = in_fetch;
    assign imem_addr_o  = pc_q;
    assign instr_o      = instr_q;
    assign dmem_req_o   = in_mem;
    assign dmem_we_o    = in_mem && mem_w_i;
    assign rf_we_o      = (state_q == ST_WRITEBACK) && reg_w_i;
    assign trap_o       = state_q == ST_TRAP;
    assign trap_cause_o = cause_q;
    assign pc_o         = pc_q;
    assign state_o      = state_q;

endmodule
